modexp_arbiter: RTL and testbench
=================================

MODEXP_ARBITER -- requirements
Module: modexp_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing the engine.
REQ-002 SHALL have parameter W, default 32, operand/result width.
REQ-003 SHALL have parameter TIMEOUT, default 4096, maximum engine cycles before abort.
REQ-004 SHALL use one clock; reset is asynchronous and active-low: clk  in  1  rising-edge clock.
REQ-005 rstn  in  1  asynchronous active-low reset.
REQ-006 req  in  NREQ  per-requester level request.
REQ-007 base_i, exp_i, mod_i  in  NREQ*W each  packed per-requester operands; slice i belongs to requester i.
REQ-008 ack  out  NREQ  one-cycle pulse: operands of requester i captured.
REQ-009 done  out  NREQ  one-cycle pulse: res valid for requester i.
REQ-010 err  out  NREQ  one-cycle pulse: requester i operation aborted on timeout.
REQ-011 res  out  W  result; valid only in done cycle, holds last value otherwise.
REQ-012 busy  out  1  high in any state other than IDLE.
REQ-013 eng_gen  out  1  engine start, level, held until eng_end.
REQ-014 eng_base, eng_exp, eng_mod  out  W each  latched operands to engine.
REQ-015 eng_res  in  W  engine result; eng_end  in  1  engine finished, held while eng_gen high.

Function
REQ-016 SHALL implement states IDLE, RUN, RELEASE; all outputs registered.
REQ-017 IDLE: if req nonzero, grant the first set bit searching upward (with wrap) from ptr+1; capture slice g to eng_* registers; pulse ack[g]; set eng_gen=1; clear counter; go RUN. Latency: req sampled high at edge n -> ack and eng_gen high after edge n.
REQ-018 IDLE: with req zero, stay in IDLE, all pulses low.
REQ-019 RUN: counter increments each cycle; on eng_end=1, latch res<=eng_res, pulse done[g], eng_gen<=0, ptr<=g, go RELEASE.
REQ-020 RUN: if counter reaches TIMEOUT-1 with eng_end=0, pulse err[g], eng_gen<=0, ptr<=g, res unchanged, go RELEASE.
REQ-021 eng_end and timeout in the same cycle: eng_end wins (done, not err).
REQ-022 RELEASE: wait until eng_end=0, then IDLE; no new grant before eng_end low.
REQ-023 req is sampled only in IDLE; dropping req[g] during RUN does not cancel, and done[g] is still issued.
REQ-024 Requester holding req after done is re-granted only after all other pending requesters (round-robin fairness); a sole requester is re-granted at the first IDLE cycle.
REQ-025 eng_* operands SHALL stay stable from grant until leaving RUN.
REQ-026 At most one bit of ack|done|err SHALL be high in any cycle.

Reset
REQ-027 rstn low SHALL immediately force state IDLE, ptr=NREQ-1 (so requester 0 wins first), eng_gen=0, ack=done=err=0, busy=0, res=0, eng_* operands=0, counter=0.
REQ-028 Reset mid-RUN SHALL abort silently: no done/err pulse; after release, behaviour as after power-up.

Structure
REQ-029 State encoding, default W, NREQ and TIMEOUT SHALL live in shared package ot_pkg.
REQ-030 Round-robin selection SHALL be a sub-module rr_picker (inputs req, ptr; outputs grant index, any).
REQ-031 Counter width SHALL be clog2(TIMEOUT); total RTL 120-400 lines.

Verification (bench models engine: eng_end N cycles after eng_gen, held until gen drops)
REQ-032 Single: req[1]=1, base=4, exp=13, mod=497, engine latency 10 -> ack[1] next cycle, done[1] with res=445, busy low after release.
REQ-033 Contention: req=4'b1111 held -> grant order 0,1,2,3,0; each done exactly once per turn.
REQ-034 Timeout: TIMEOUT=16, engine never ends -> err[2] after 16 RUN cycles, eng_gen low, res unchanged, next request served normally.
REQ-035 Tie: eng_end rises on timeout cycle -> done pulse, no err.
REQ-036 Reset mid-RUN: rstn low 3 cycles during RUN -> all outputs 0 immediately, no done/err; next req[3] granted before lower bits only if alone, else requester 0 first.
REQ-037 Req drop: req[0] falls one cycle after ack -> done[0] still asserted with correct res.

Source files
------------

// File: rtl/ot_pkg.sv
// Shared definitions for the modular-exponentiation engine arbiter.
// Holds default sizing, the controller state encoding and a width helper.
package ot_pkg;

  localparam int unsigned NREQ_DEF    = 4;
  localparam int unsigned W_DEF       = 32;
  localparam int unsigned TIMEOUT_DEF = 4096;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StRelease = 2'd2
  } state_e;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin requester selection: first set request bit searching upward
// from ptr+1 with wrap-around, so the last winner gets lowest priority.
module rr_picker
  import ot_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0]         req,
  input  logic [idx_w(NREQ)-1:0]  ptr,
  output logic [idx_w(NREQ)-1:0]  grant,
  output logic                    any
);

  localparam int unsigned IW = idx_w(NREQ);

  logic [IW-1:0] cand;

  always_comb begin
    grant = ptr;
    any   = 1'b0;
    cand  = ptr;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IW'((32'(ptr) + k) % NREQ);
      if (!any && req[cand]) begin
        any   = 1'b1;
        grant = cand;
      end
    end
  end

endmodule

// File: rtl/modexp_arbiter.sv
// Shares one modular-exponentiation engine among NREQ requesters with
// round-robin fairness, a run-time watchdog and fully registered outputs.
module modexp_arbiter
  import ot_pkg::*;
#(
  parameter int unsigned NREQ    = NREQ_DEF,
  parameter int unsigned W       = W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] base_i,
  input  logic [NREQ*W-1:0] exp_i,
  input  logic [NREQ*W-1:0] mod_i,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   done,
  output logic [NREQ-1:0]   err,
  output logic [W-1:0]      res,
  output logic              busy,
  output logic              eng_gen,
  output logic [W-1:0]      eng_base,
  output logic [W-1:0]      eng_exp,
  output logic [W-1:0]      eng_mod,
  input  logic [W-1:0]      eng_res,
  input  logic              eng_end
);

  localparam int unsigned   IW      = idx_w(NREQ);
  localparam int unsigned   CW      = idx_w(TIMEOUT);
  localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);

  state_e state_q, state_d;

  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [NREQ-1:0] err_q, err_d;
  logic [W-1:0]    res_q, res_d;
  logic            busy_q, busy_d;
  logic            gen_q, gen_d;
  logic [W-1:0]    base_q, base_d;
  logic [W-1:0]    exp_q, exp_d;
  logic [W-1:0]    mod_q, mod_d;

  logic [IW-1:0] pick;
  logic          pick_any;

  rr_picker #(
    .NREQ (NREQ)
  ) u_rr_picker (
    .req   (req),
    .ptr   (ptr_q),
    .grant (pick),
    .any   (pick_any)
  );

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; eng_end takes precedence over the watchdog.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (pick_any) state_d = StRun;
      StRun:     if (eng_end || (cnt_q == CntLast)) state_d = StRelease;
      StRelease: if (!eng_end) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Output and datapath next values; pulses default low every cycle.
  always_comb begin
    ptr_d  = ptr_q;
    gnt_d  = gnt_q;
    cnt_d  = cnt_q;
    ack_d  = '0;
    done_d = '0;
    err_d  = '0;
    res_d  = res_q;
    gen_d  = gen_q;
    base_d = base_q;
    exp_d  = exp_q;
    mod_d  = mod_q;
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          gnt_d       = pick;
          ack_d[pick] = 1'b1;
          gen_d       = 1'b1;
          cnt_d       = '0;
          base_d      = base_i[32'(pick) * W +: W];
          exp_d       = exp_i[32'(pick) * W +: W];
          mod_d       = mod_i[32'(pick) * W +: W];
        end
      end
      StRun: begin
        if (eng_end) begin
          res_d         = eng_res;
          done_d[gnt_q] = 1'b1;
          gen_d         = 1'b0;
          ptr_d         = gnt_q;
        end else if (cnt_q == CntLast) begin
          err_d[gnt_q] = 1'b1;
          gen_d        = 1'b0;
          ptr_d        = gnt_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
    busy_d = (state_d != StIdle);
  end

  // Datapath and output registers; ptr resets so requester 0 wins first.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q  <= IW'(NREQ - 1);
      gnt_q  <= '0;
      cnt_q  <= '0;
      ack_q  <= '0;
      done_q <= '0;
      err_q  <= '0;
      res_q  <= '0;
      busy_q <= 1'b0;
      gen_q  <= 1'b0;
      base_q <= '0;
      exp_q  <= '0;
      mod_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      gnt_q  <= gnt_d;
      cnt_q  <= cnt_d;
      ack_q  <= ack_d;
      done_q <= done_d;
      err_q  <= err_d;
      res_q  <= res_d;
      busy_q <= busy_d;
      gen_q  <= gen_d;
      base_q <= base_d;
      exp_q  <= exp_d;
      mod_q  <= mod_d;
    end
  end

  assign ack      = ack_q;
  assign done     = done_q;
  assign err      = err_q;
  assign res      = res_q;
  assign busy     = busy_q;
  assign eng_gen  = gen_q;
  assign eng_base = base_q;
  assign eng_exp  = exp_q;
  assign eng_mod  = mod_q;

endmodule

// File: tb/tb_modexp_arbiter.sv
// Directed bench for modexp_arbiter with a latency-programmable engine model.
module tb_modexp_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned W       = 32;
  localparam int unsigned TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rstn;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] base_i, exp_i, mod_i;
  logic [NREQ-1:0]   ack, done, err;
  logic [W-1:0]      res;
  logic              busy, eng_gen;
  logic [W-1:0]      eng_base, eng_exp, eng_mod, eng_res;
  logic              eng_end;

  int lat;
  int ecnt;
  int n_checks = 0;
  int n_pass   = 0;
  int cyc;

  // Hand-computed results: 2^10%1000, 4^13%497, 3^4%7, 5^3%13.
  logic [31:0] exp_res [NREQ] = '{32'd24, 32'd445, 32'd4, 32'd8};
  int          order   [5]    = '{0, 1, 2, 3, 0};

  modexp_arbiter #(
    .NREQ    (NREQ),
    .W       (W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .req      (req),
    .base_i   (base_i),
    .exp_i    (exp_i),
    .mod_i    (mod_i),
    .ack      (ack),
    .done     (done),
    .err      (err),
    .res      (res),
    .busy     (busy),
    .eng_gen  (eng_gen),
    .eng_base (eng_base),
    .eng_exp  (eng_exp),
    .eng_mod  (eng_mod),
    .eng_res  (eng_res),
    .eng_end  (eng_end)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] modexp(input logic [31:0] b, input logic [31:0] e,
                                         input logic [31:0] m);
    logic [63:0] r;
    logic [63:0] x;
    if (m == 32'd0) return 32'd0;
    r = 64'd1 % 64'(m);
    x = 64'(b) % 64'(m);
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = (r * x) % 64'(m);
      x = (x * x) % 64'(m);
    end
    return r[31:0];
  endfunction

  // Engine: eng_end rises lat cycles after eng_gen (never when lat is 0).
  always_comb eng_res = modexp(eng_base, eng_exp, eng_mod);

  always_ff @(posedge clk) begin
    if (!eng_gen) begin
      ecnt    <= 0;
      eng_end <= 1'b0;
    end else begin
      ecnt <= ecnt + 1;
      if (lat != 0 && ecnt + 1 == lat) eng_end <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      n_checks++;
      assert ($countones(ack | done | err) <= 1) n_pass++;
      else $error("FAIL onehot: got %b required at most one bit", ack | done | err);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: got %0h required %0h", tag, obs, expv);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_evt(output int c);
    c = -1;
    for (int k = 1; k <= 100; k++) begin
      step();
      if ((done | err) != '0) begin
        c = k;
        break;
      end
    end
  endtask

  task automatic wait_ack(output int c);
    c = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (ack != '0) begin
        c = k;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 50; k++) begin
      if (!busy) break;
      step();
    end
    chk("idle", 64'(busy), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rstn   = 1'b0;
    req    = '0;
    lat    = 3;
    base_i = {32'd5, 32'd3, 32'd4, 32'd2};
    exp_i  = {32'd3, 32'd4, 32'd13, 32'd10};
    mod_i  = {32'd13, 32'd7, 32'd497, 32'd1000};
    repeat (2) step();
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_pulses", 64'(done | err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_gen", 64'(eng_gen), 64'd0);
    chk("rst_res", 64'(res), 64'd0);
    chk("rst_base", 64'(eng_base), 64'd0);
    rstn = 1'b1;

    // Contention: all four held, expect 0,1,2,3,0.
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_ack(cyc);
      chk("rr_ack", 64'(ack), 64'd1 << order[t]);
      if (t == 4) req = '0;
      wait_evt(cyc);
      chk("rr_done", 64'(done), 64'd1 << order[t]);
      chk("rr_err", 64'(err), 64'd0);
      chk("rr_res", 64'(res), 64'(exp_res[order[t]]));
      step();
      chk("rr_done_once", 64'(done), 64'd0);
    end
    wait_idle();

    // Single request from requester 1, engine latency 10.
    lat = 10;
    req = 4'b0010;
    step();
    chk("single_ack", 64'(ack), 64'd2);
    chk("single_gen", 64'(eng_gen), 64'd1);
    chk("single_busy", 64'(busy), 64'd1);
    chk("single_base", 64'(eng_base), 64'd4);
    chk("single_exp", 64'(eng_exp), 64'd13);
    chk("single_mod", 64'(eng_mod), 64'd497);
    req = '0;
    wait_evt(cyc);
    chk("single_lat", 64'(cyc), 64'd11);
    chk("single_done", 64'(done), 64'd2);
    chk("single_err", 64'(err), 64'd0);
    chk("single_res", 64'(res), 64'd445);
    step();
    chk("single_done_once", 64'(done), 64'd0);
    step();
    chk("single_busy_low", 64'(busy), 64'd0);
    chk("single_res_hold", 64'(res), 64'd445);

    // Requester 0 drops its request one cycle after ack.
    lat = 6;
    req = 4'b0001;
    step();
    chk("drop_ack", 64'(ack), 64'd1);
    step();
    req = '0;
    wait_evt(cyc);
    chk("drop_done", 64'(done), 64'd1);
    chk("drop_res", 64'(res), 64'd24);
    wait_idle();

    // Engine never finishes: watchdog fires on requester 2.
    lat = 0;
    req = 4'b0100;
    step();
    chk("to_ack", 64'(ack), 64'd4);
    req = '0;
    wait_evt(cyc);
    chk("to_cycles", 64'(cyc), 64'd16);
    chk("to_err", 64'(err), 64'd4);
    chk("to_done", 64'(done), 64'd0);
    chk("to_gen", 64'(eng_gen), 64'd0);
    chk("to_res_hold", 64'(res), 64'd24);
    wait_idle();
    lat = 4;
    req = 4'b1000;
    step();
    chk("after_to_ack", 64'(ack), 64'd8);
    req = '0;
    wait_evt(cyc);
    chk("after_to_done", 64'(done), 64'd8);
    chk("after_to_res", 64'(res), 64'd8);
    wait_idle();

    // eng_end arrives on the final watchdog cycle: done wins.
    lat = 15;
    req = 4'b0010;
    step();
    chk("tie_ack", 64'(ack), 64'd2);
    req = '0;
    wait_evt(cyc);
    chk("tie_cycles", 64'(cyc), 64'd16);
    chk("tie_done", 64'(done), 64'd2);
    chk("tie_err", 64'(err), 64'd0);
    chk("tie_res", 64'(res), 64'd445);
    wait_idle();

    // Reset in the middle of a run aborts silently.
    lat = 10;
    req = 4'b0010;
    step();
    chk("mid_ack", 64'(ack), 64'd2);
    req = '0;
    repeat (3) step();
    chk("mid_busy", 64'(busy), 64'd1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_gen", 64'(eng_gen), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_res", 64'(res), 64'd0);
    chk("mid_rst_base", 64'(eng_base), 64'd0);
    chk("mid_rst_pulses", 64'(ack | done | err), 64'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("mid_rst_quiet", 64'(done | err), 64'd0);
    end
    rstn = 1'b1;
    lat  = 3;
    req  = 4'b1001;
    step();
    chk("post_rst_ack", 64'(ack), 64'd1);
    req = '0;
    wait_evt(cyc);
    chk("post_rst_done", 64'(done), 64'd1);
    chk("post_rst_res", 64'(res), 64'd24);
    wait_idle();
    req = 4'b1000;
    step();
    chk("alone_ack", 64'(ack), 64'd8);
    req = '0;
    wait_evt(cyc);
    chk("alone_done", 64'(done), 64'd8);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
